psum_accumulator: RTL

Downstream partner of the PE's unsigned multiplier: consumes a stream of products, adds them onto an incoming partial sum, and emits the finished partial sum to the next PE or psum scratchpad. One accumulation "job" is one psum_in handshake, then `cfg_acc_len` product handshakes, then one psum_out handshake. Accumulation is unsigned and saturating, with a sticky overflow flag per job.

---
 rtl/pe_pkg.sv | 14 +
 rtl/sat_adder.sv | 20 ++
 rtl/psum_accumulator.sv | 95 +++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared PE definitions: default datapath widths and the accumulator FSM encoding.
package pe_pkg;

  localparam int PE_PROD_WIDTH = 16;
  localparam int PE_PSUM_WIDTH = 20;
  localparam int PE_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/sat_adder.sv
// Unsigned saturating adder: clamps to all-ones when the carry-out is set.
module sat_adder #(
  parameter int width = 20
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] sum,
  output logic             ovf
);

  logic [width:0] full;

  // Add with one guard bit; the guard bit is the overflow indication.
  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[width];
    sum  = full[width] ? {width{1'b1}} : full[width-1:0];
  end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: one psum_in, cfg_acc_len products, one psum_out per job.
// Saturating unsigned accumulation with a sticky per-job overflow flag.
module psum_accumulator
  import pe_pkg::*;
#(
  parameter int prod_width = PE_PROD_WIDTH,
  parameter int psum_width = PE_PSUM_WIDTH,
  parameter int len_width  = PE_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [len_width-1:0]  cfg_acc_len,
  input  logic                  psum_in_valid,
  output logic                  psum_in_ready,
  input  logic [psum_width-1:0] psum_in,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [prod_width-1:0] prod,
  output logic                  psum_out_valid,
  input  logic                  psum_out_ready,
  output logic [psum_width-1:0] psum_out,
  output logic                  psum_ovf
);

  acc_state_e            state_q, state_d;
  logic [psum_width-1:0] acc_q;
  logic [len_width-1:0]  rem_q;
  logic                  ovf_q;

  logic [psum_width-1:0] prod_ext;
  logic [psum_width-1:0] sum;
  logic                  sum_ovf;
  logic                  psum_in_fire;
  logic                  prod_fire;

  // Handshake decodes come straight from the registered state, so no
  // valid input ever reaches a ready output combinationally.
  assign psum_in_ready  = (state_q == IDLE);
  assign prod_ready     = (state_q == ACCUM);
  assign psum_out_valid = (state_q == DONE);
  assign psum_out       = acc_q;
  assign psum_ovf       = ovf_q;

  assign psum_in_fire = psum_in_valid && psum_in_ready;
  assign prod_fire    = prod_valid && prod_ready;

  // Zero-extend the product to the accumulator width.
  always_comb begin
    prod_ext                   = '0;
    prod_ext[prod_width-1:0]   = prod;
  end

  sat_adder #(.width(psum_width)) u_sat_adder (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (sum),
    .ovf (sum_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: zero-length jobs pass straight through to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (psum_in_fire) state_d = (cfg_acc_len == '0) ? DONE : ACCUM;
      ACCUM:   if (prod_fire && rem_q == len_width'(1)) state_d = DONE;
      DONE:    if (psum_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on psum_in, accumulate on each product, otherwise hold.
  // remaining is always >= 1 while in ACCUM, so the decrement cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      rem_q <= '0;
      ovf_q <= 1'b0;
    end else if (psum_in_fire) begin
      acc_q <= psum_in;
      rem_q <= cfg_acc_len;
      ovf_q <= 1'b0;
    end else if (prod_fire) begin
      acc_q <= sum;
      rem_q <= rem_q - len_width'(1);
      ovf_q <= ovf_q | sum_ovf;
    end
  end

endmodule
